// File: rtl/rsa_pkg.sv
// rtl/rsa_pkg.sv - shared RSA datapath constants and FSM state type
package rsa_pkg;

   localparam int WIDTH = 256;
   localparam int CNT_W = $clog2(WIDTH) + 1;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      CALC  = 2'd1,
      FINAL = 2'd2
   } state_t;

endpackage

// File: rtl/montgomery_product.sv
// rtl/montgomery_product.sv - radix-2 Montgomery multiplier, m = a*b*2^-WIDTH mod N
module montgomery_product
   import rsa_pkg::*;
#(
   parameter int WIDTH = rsa_pkg::WIDTH
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] N,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic [WIDTH-1:0] m,
   output logic             finish
);

   state_t             state;
   state_t             state_next;
   logic [CNT_W-1:0]   i;
   logic [WIDTH-1:0]   n_reg;
   logic [WIDTH-1:0]   a_reg;
   logic [WIDTH-1:0]   b_reg;
   logic [WIDTH+1:0]   acc;
   logic [WIDTH+1:0]   acc_next;
   logic [WIDTH+1:0]   t;
   logic [WIDTH+1:0]   n_ext;
   logic [WIDTH+1:0]   diff;
   logic               last_iter;

   assign n_ext     = {2'b00, n_reg};
   assign diff      = acc - n_ext;
   assign last_iter = (i == CNT_W'(WIDTH - 1));

   always_comb begin
      state_next = state;
      case (state)
         IDLE:    if (start) state_next = CALC;
         CALC:    if (last_iter) state_next = FINAL;
         FINAL:   state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   // One radix-2 step: add b if the current multiplier bit is set, make even with N, halve.
   always_comb begin
      t = acc;
      if (a_reg[i[CNT_W-2:0]]) t = t + {2'b00, b_reg};
      if (t[0]) t = t + n_ext;
      acc_next = t >> 1;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state  <= IDLE;
         i      <= '0;
         acc    <= '0;
         n_reg  <= '0;
         a_reg  <= '0;
         b_reg  <= '0;
         m      <= '0;
         finish <= 1'b0;
      end else begin
         state  <= state_next;
         finish <= 1'b0;
         case (state)
            IDLE: begin
               if (start) begin
                  n_reg <= N;
                  a_reg <= a;
                  b_reg <= b;
                  acc   <= '0;
                  i     <= '0;
               end
            end
            CALC: begin
               acc <= acc_next;
               i   <= i + 1'b1;
            end
            FINAL: begin
               // acc < 2N, so a single conditional subtraction fully reduces it.
               m      <= (acc >= n_ext) ? diff[WIDTH-1:0] : acc[WIDTH-1:0];
               finish <= 1'b1;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: doc/montgomery_product.md
# montgomery_product

- Radix-2 Montgomery multiplier: computes m = a·b·2^-256 mod N for 256-bit operands over 256 iteration cycles plus one correction cycle.
- Sits directly downstream of the modulo_product pre-scaler in the RSA datapath.
- Consumes the Montgomery-domain value y·2^256 mod N produced there and serves as the square/multiply engine of the exponentiation loop.

## Interface
Parameters:
- WIDTH, 256, operand/modulus bit width; iteration count equals WIDTH.

Ports:
- clk  input  1  single clock, rising-edge.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  single-cycle request; sampled only in IDLE.
- N  input  WIDTH  modulus; odd; sampled on the accepted start edge.
- a  input  WIDTH  multiplier operand, a < N; sampled on the accepted start edge.
- b  input  WIDTH  multiplicand operand, b < N; sampled on the accepted start edge.
- m  output  WIDTH  result; holds its value until the next accepted start.
- finish  output  1  registered one-cycle pulse: m is valid.

## Operation
- States:
  - IDLE → CALC on start=1.
  - CALC → FINAL when iteration counter = WIDTH-1.
  - FINAL → IDLE unconditionally.
- Accept edge (IDLE, start=1):
  - register N, a, b.
  - clear accumulator acc (WIDTH+2 bits) to 0.
  - clear counter i to 0.
- CALC edge, iteration i:
  - t = acc + (a_reg[i] ? b_reg : 0).
  - if t[0]=1: t = t + N_reg.
  - acc ← t >> 1.
  - i ← i+1.
- Width rule: acc and t are WIDTH+2 bits. Invariant acc < 2N holds, so no bit is lost for N up to 2^WIDTH-1.
- FINAL edge:
  - m ← (acc ≥ N_reg) ? acc − N_reg : acc, truncated to WIDTH.
  - finish ← 1.
- finish clears on the next edge.
- start while in CALC/FINAL: ignored. No queueing, no effect on the operation in progress.
- start in the same cycle finish is high: accepted, since the FSM is already back in IDLE.
- Even N or operands ≥ N: result undefined. Timing and handshake are unchanged.

## Timing
- Reset values:
  - state=IDLE, i=0, acc=0.
  - m=0, finish=0.
  - N/a/b registers = 0.
- Reset mid-operation: the same values are applied immediately. No finish pulse is issued for the aborted operation.
- Latency, with start accepted at edge E0:
  - iterations occupy edges E1..E256.
  - correction at E257.
  - m and finish=1 become visible after E257.
  - finish=0 after E258.
- Throughput: one result per 258 cycles when start is re-asserted during the finish cycle.
- m changes only at FINAL edges and on reset.

## Structure
- Shared package rsa_pkg:
  - WIDTH constant (256).
  - FSM state enum (IDLE, CALC, FINAL).
  - modulo_product and the exponentiation controller use the same package.
- Counter width: $clog2(WIDTH)+1 bits, declared from the package constant.
- No sub-module. The per-iteration add/add/shift is a single combinational always block inside this module.
- Expected RTL size: ~150 lines.

## Test plan
- N=3, a=1, b=1, start pulse → finish exactly 257 cycles after the accept edge, m=1.
- N=7, a=3, b=5 → m=4 (15·2^-256 mod 7). finish is high for one cycle only.
- N=2^256−1, a=b=N−1 → m=1. Exercises the WIDTH+2 accumulator and the final subtraction.
- N=5, a=2, b=3 → m=1, with start held high for 10 extra cycles during CALC:
  - no second operation starts.
  - finish pulses once.
- rst asserted at iteration 100 of an N=7 operation:
  - m=0, finish=0 immediately.
  - no finish afterwards.
  - a new start completes normally.
- Back-to-back: second start (N=7, a=3, b=5) asserted in the finish cycle of a first operation (N=3, a=1, b=1):
  - results 1 then 4.
  - finish pulses exactly 258 cycles apart.
